// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcodes, FSM states and select reset values
package ctrl_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic RST_ALU_OP1_SEL = 1'b1;
  localparam logic RST_ALU_OP2_SEL = 1'b1;
  localparam logic RST_JB_OP1_SEL  = 1'b0;
  localparam logic RST_WB_SEL      = 1'b0;
  localparam logic RST_NEXT_PC_SEL = 1'b1;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode decode into select bundle and class flags
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic       o_op1_sel,
  output logic       o_op2_sel,
  output logic       o_jb1_sel,
  output logic       o_wb_sel,
  output logic       o_is_mem,
  output logic       o_is_store,
  output logic       o_is_branch,
  output logic       o_is_jump,
  output logic       o_writes_rd,
  output logic       o_illegal
);

  always_comb begin
    o_op1_sel   = 1'b1;
    o_op2_sel   = 1'b0;
    o_jb1_sel   = 1'b0;
    o_wb_sel    = 1'b0;
    o_is_mem    = 1'b0;
    o_is_store  = 1'b0;
    o_is_branch = 1'b0;
    o_is_jump   = 1'b0;
    o_writes_rd = 1'b1;
    o_illegal   = 1'b0;
    case (i_opcode)
      OP:     o_op2_sel = 1'b1;
      OP_IMM: ;
      LOAD: begin
        o_wb_sel = 1'b1;
        o_is_mem = 1'b1;
      end
      STORE: begin
        o_is_mem    = 1'b1;
        o_is_store  = 1'b1;
        o_writes_rd = 1'b0;
      end
      LUI, AUIPC: o_op1_sel = 1'b0;
      JAL: begin
        o_op1_sel = 1'b0;
        o_is_jump = 1'b1;
      end
      JALR: begin
        o_jb1_sel = 1'b1;
        o_is_jump = 1'b1;
      end
      BRANCH: begin
        o_op2_sel   = 1'b1;
        o_is_branch = 1'b1;
        o_writes_rd = 1'b0;
      end
      default: begin
        o_writes_rd = 1'b0;
        o_illegal   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I datapath
module multicycle_controller
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        im_ready,
  input  logic        dm_ready,
  input  logic        b_taken,
  output logic        im_req,
  output logic        ir_we,
  output logic        dm_req,
  output logic        dm_we,
  output logic        reg_we,
  output logic        pc_we,
  output logic        alu_op1_sel,
  output logic        alu_op2_sel,
  output logic        jb_op1_sel,
  output logic        wb_sel,
  output logic        next_pc_sel,
  output logic        retire,
  output logic        halted
);

  state_t r_state, w_next_state;

  logic w_op1, w_op2, w_jb1, w_wb;
  logic w_is_mem, w_is_store, w_is_branch, w_is_jump, w_writes_rd, w_illegal;
  logic w_unused;

  logic r_op1, r_op2, r_jb1, r_wb, r_next_pc;
  logic r_is_mem, r_is_store, r_is_branch, r_is_jump, r_rd_write;

  assign w_unused = ^inst[31:12];

  ctrl_decode u_decode (
    .i_opcode    (inst[6:0]),
    .o_op1_sel   (w_op1),
    .o_op2_sel   (w_op2),
    .o_jb1_sel   (w_jb1),
    .o_wb_sel    (w_wb),
    .o_is_mem    (w_is_mem),
    .o_is_store  (w_is_store),
    .o_is_branch (w_is_branch),
    .o_is_jump   (w_is_jump),
    .o_writes_rd (w_writes_rd),
    .o_illegal   (w_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:  if (im_ready) w_next_state = S_DECODE;
      S_DECODE: w_next_state = w_illegal ? S_HALT : S_EXEC;
      S_EXEC:   w_next_state = r_is_mem ? S_MEM : S_WB;
      S_MEM:    if (dm_ready) w_next_state = S_WB;
      S_WB:     w_next_state = S_FETCH;
      S_HALT:   w_next_state = S_HALT;
      default:  w_next_state = S_FETCH;
    endcase
  end

  // Selects and class flags are captured once in DECODE so the datapath
  // sees them stable through MEM/WB even if inst changes afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op1       <= RST_ALU_OP1_SEL;
      r_op2       <= RST_ALU_OP2_SEL;
      r_jb1       <= RST_JB_OP1_SEL;
      r_wb        <= RST_WB_SEL;
      r_next_pc   <= RST_NEXT_PC_SEL;
      r_is_mem    <= 1'b0;
      r_is_store  <= 1'b0;
      r_is_branch <= 1'b0;
      r_is_jump   <= 1'b0;
      r_rd_write  <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_op1       <= w_op1;
      r_op2       <= w_op2;
      r_jb1       <= w_jb1;
      r_wb        <= w_wb;
      r_is_mem    <= w_is_mem;
      r_is_store  <= w_is_store;
      r_is_branch <= w_is_branch;
      r_is_jump   <= w_is_jump;
      r_rd_write  <= w_writes_rd && (inst[11:7] != 5'd0);
    end else if (r_state == S_EXEC) begin
      if (r_is_jump)        r_next_pc <= 1'b0;
      else if (r_is_branch) r_next_pc <= ~b_taken;
      else                  r_next_pc <= 1'b1;
    end
  end

  always_comb begin
    im_req = 1'b0;
    ir_we  = 1'b0;
    dm_req = 1'b0;
    dm_we  = 1'b0;
    reg_we = 1'b0;
    pc_we  = 1'b0;
    retire = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          im_req = 1'b1;
          ir_we  = im_ready;
        end
        S_MEM: begin
          dm_req = 1'b1;
          dm_we  = r_is_store;
        end
        S_WB: begin
          pc_we  = 1'b1;
          retire = 1'b1;
          reg_we = r_rd_write;
        end
        default: ;
      endcase
    end
  end

  assign halted      = (r_state == S_HALT) && !rst;
  assign alu_op1_sel = r_op1;
  assign alu_op2_sel = r_op2;
  assign jb_op1_sel  = r_jb1;
  assign wb_sel      = r_wb;
  assign next_pc_sel = r_next_pc;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        im_ready, dm_ready, b_taken;
  logic        im_req, ir_we, dm_req, dm_we, reg_we, pc_we;
  logic        alu_op1_sel, alu_op2_sel, jb_op1_sel, wb_sel, next_pc_sel;
  logic        retire, halted;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .inst(inst), .im_ready(im_ready), .dm_ready(dm_ready),
    .b_taken(b_taken), .im_req(im_req), .ir_we(ir_we), .dm_req(dm_req), .dm_we(dm_we),
    .reg_we(reg_we), .pc_we(pc_we), .alu_op1_sel(alu_op1_sel), .alu_op2_sel(alu_op2_sel),
    .jb_op1_sel(jb_op1_sel), .wb_sel(wb_sel), .next_pc_sel(next_pc_sel),
    .retire(retire), .halted(halted)
  );

  typedef struct {
    logic reg_we; logic wb; logic op1; logic op2; logic jb1; logic npc; logic store;
    int   lat;    int   dmc;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc = 0, dmc = 0, irc = 0;
  logic seen_dm_we = 1'b0;

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference: the opcode table, rd==x0 suppression and per-phase cycle counts.
  function automatic exp_t model(input logic [31:0] ins, input int iw, input int dw, input logic bt);
    exp_t e;
    logic mem;
    e.op1 = 1; e.op2 = 0; e.jb1 = 0; e.wb = 0; e.npc = 1; e.store = 0; e.reg_we = 1;
    mem = 0;
    case (ins[6:0])
      7'h33: e.op2 = 1;
      7'h03: begin e.wb = 1; mem = 1; end
      7'h23: begin mem = 1; e.store = 1; e.reg_we = 0; end
      7'h37, 7'h17: e.op1 = 0;
      7'h6F: begin e.op1 = 0; e.npc = 0; end
      7'h67: begin e.jb1 = 1; e.npc = 0; end
      7'h63: begin e.op2 = 1; e.npc = ~bt; e.reg_we = 0; end
      default: ;
    endcase
    if (ins[11:7] == 5'd0) e.reg_we = 0;
    e.dmc = mem ? dw + 1 : 0;
    e.lat = iw + 4 + e.dmc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      cyc = 0; dmc = 0; irc = 0;
    end else begin
      cyc++;
      if (dm_req) begin dmc++; seen_dm_we = dm_we; end
      if (ir_we) irc++;
      if (!retire) begin
        chki("strobe_outside_wb", {30'd0, reg_we, pc_we}, 0);
      end else if (q.size() == 0) begin
        chki("unexpected_retire", 1, 0);
      end else begin
        m_e = q.pop_front();
        chki("latency", cyc, m_e.lat);
        chki("dm_req_cycles", dmc, m_e.dmc);
        chki("ir_we_count", irc, 1);
        chki("pc_we", 32'(pc_we), 1);
        chki("reg_we", 32'(reg_we), 32'(m_e.reg_we));
        chki("alu_op1_sel", 32'(alu_op1_sel), 32'(m_e.op1));
        chki("alu_op2_sel", 32'(alu_op2_sel), 32'(m_e.op2));
        chki("jb_op1_sel", 32'(jb_op1_sel), 32'(m_e.jb1));
        chki("wb_sel", 32'(wb_sel), 32'(m_e.wb));
        chki("next_pc_sel", 32'(next_pc_sel), 32'(m_e.npc));
        if (m_e.dmc > 0) chki("dm_we", 32'(seen_dm_we), 32'(m_e.store));
        cyc = 0; dmc = 0; irc = 0;
      end
    end
  end

  task automatic drive(input logic ir, input logic dr, input logic bt);
    im_ready = ir; dm_ready = dr; b_taken = bt;
    @(posedge clk); #1;
  endtask

  task automatic run_inst(input logic [31:0] ins, input int iw, input int dw, input logic bt, input int pre);
    exp_t e;
    e = model(ins, iw + pre, dw, bt);
    q.push_back(e);
    inst = ins;
    repeat (iw) drive(1'b0, rb(), rb());
    drive(1'b1, rb(), rb());
    drive(rb(), rb(), rb());
    drive(rb(), rb(), bt);
    if (e.dmc > 0) begin
      repeat (dw) drive(rb(), 1'b0, rb());
      drive(rb(), 1'b1, rb());
    end
    drive(rb(), rb(), rb());
  endtask

  logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63};

  initial begin
    logic [31:0] r;
    rst = 1'b1; inst = 32'h0; im_ready = 0; dm_ready = 0; b_taken = 0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chki("reset_strobes", {25'd0, im_req, ir_we, dm_req, dm_we, reg_we, pc_we, retire}, 0);
    chki("reset_halted", 32'(halted), 0);
    chki("reset_selects", {27'd0, alu_op1_sel, alu_op2_sel, jb_op1_sel, wb_sel, next_pc_sel}, 32'b11001);
    @(posedge clk); #1;
    rst = 1'b0;

    run_inst(32'h00500093, 0, 0, 1'b0, 0);
    run_inst(32'h0000A103, 0, 2, 1'b0, 0);
    run_inst(32'h00208463, 0, 0, 1'b1, 0);
    run_inst(32'h00208463, 0, 0, 1'b0, 0);
    run_inst(32'h00100013, 0, 0, 1'b1, 0);
    run_inst(32'h000080E7, 0, 0, 1'b1, 0);
    run_inst(32'h0020A023, 1, 0, 1'b0, 0);

    for (int i = 0; i < 200; i++) begin
      r = $urandom();
      run_inst({r[31:7], ops[$urandom_range(0, 8)]}, $urandom_range(0, 2),
               $urandom_range(0, 3), rb(), 0);
    end

    // Reset while a store is waiting in MEM.
    inst = 32'h0020A023;
    drive(1'b1, 1'b0, rb());
    drive(1'b0, 1'b0, rb());
    drive(1'b0, 1'b0, rb());
    im_ready = 0; dm_ready = 0;
    @(negedge clk);
    chki("mem_dm_req_before_reset", 32'(dm_req), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chki("dm_req_in_reset", 32'(dm_req), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chki("after_reset_dm_req", 32'(dm_req), 0);
    chki("after_reset_im_req", 32'(im_req), 1);
    chki("after_reset_selects", {27'd0, alu_op1_sel, alu_op2_sel, jb_op1_sel, wb_sel, next_pc_sel}, 32'b11001);
    @(posedge clk); #1;
    run_inst(32'h00500093, 0, 0, 1'b0, 1);

    // Illegal opcode: halt, stay silent, recover only through reset.
    inst = 32'h0000007F;
    drive(1'b1, rb(), rb());
    drive(rb(), rb(), rb());
    for (int i = 0; i < 10; i++) begin
      im_ready = 1'b1; dm_ready = rb(); b_taken = rb();
      @(negedge clk);
      chki("halted", 32'(halted), 1);
      chki("halt_strobes", {25'd0, im_req, ir_we, dm_req, dm_we, reg_we, pc_we, retire}, 0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; im_ready = 1'b0;
    @(negedge clk);
    chki("recover_halted", 32'(halted), 0);
    chki("recover_im_req", 32'(im_req), 1);
    @(posedge clk); #1;
    run_inst(32'h000080E7, 0, 0, 1'b0, 1);

    repeat (3) drive(1'b0, rb(), rb());
    chki("scoreboard_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
